phase_array_driver: RTL

PHASE_ARRAY_DRIVER -- requirements
Module: phase_array_driver

---
 rtl/phase_array_driver_pkg.sv | 15 +
 rtl/phase_array_driver_channel.sv | 34 +++
 rtl/phase_array_driver.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/phase_array_driver_pkg.sv
// Shared types and default constants for the phased-array transducer driver.
package phase_array_driver_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_SYNC = 2'd1,
    ST_RUN       = 2'd2
  } state_e;

  localparam int DEF_PHASE_W      = 8;
  localparam int DEF_CLK_DIV      = 5;
  localparam int DEF_DUTY         = 128;
  localparam int DEF_LOST_PERIODS = 2;

endpackage

// File: rtl/phase_array_driver_channel.sv
// One transducer channel: registered drive, high while the step is inside the
// DUTY-wide window that starts at this channel's phase offset.
module phase_channel
  import phase_array_driver_pkg::*;
#(
  parameter int PHASE_W = DEF_PHASE_W,
  parameter int DUTY    = DEF_DUTY
) (
  input  logic               sys_clk,
  input  logic               rst,
  input  logic               en_i,
  input  logic [PHASE_W-1:0] step_i,
  input  logic [PHASE_W-1:0] phase_i,
  output logic               drive_o
);

  logic [PHASE_W-1:0] offset;
  logic               drive_d;
  logic               drive_q;

  // Subtraction wraps modulo STEPS, so the window may straddle step 0.
  always_comb begin
    offset  = step_i - phase_i;
    drive_d = en_i && (offset < PHASE_W'(DUTY));
  end

  always_ff @(posedge sys_clk) begin
    if (rst) drive_q <= 1'b0;
    else     drive_q <= drive_d;
  end

  assign drive_o = drive_q;

endmodule

// File: rtl/phase_array_driver.sv
// Phased-array driver: shared prescaler/step counter, master/slave sync,
// double-buffered per-channel phase registers and N_CH drive comparators.
module phase_array_driver
  import phase_array_driver_pkg::*;
#(
  parameter int N_CH         = 2,
  parameter int PHASE_W      = DEF_PHASE_W,
  parameter int CLK_DIV      = DEF_CLK_DIV,
  parameter int DUTY         = DEF_DUTY,
  parameter int LOST_PERIODS = DEF_LOST_PERIODS,
  localparam int AW          = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic               sys_clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               slave,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [PHASE_W-1:0] wr_data,
  input  logic               commit,
  input  logic               sync_in,
  output logic               sync_out,
  output logic [N_CH-1:0]    trans,
  output logic               period_tick,
  output logic               commit_pending,
  output logic               sync_lost
);

  localparam int          PW         = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned LOST_LIMIT = LOST_PERIODS * (2 ** PHASE_W) * CLK_DIV;
  localparam int          CW         = $clog2(LOST_LIMIT + 1);

  state_e             state_q, state_d;
  logic [PW-1:0]      presc_q, presc_d;
  logic [PHASE_W-1:0] step_q, step_d;
  logic [2:0]         sync_q;
  logic               sync_edge;
  logic [PHASE_W-1:0] shadow_q [N_CH];
  logic [PHASE_W-1:0] shadow_d [N_CH];
  logic [PHASE_W-1:0] active_q [N_CH];
  logic [PHASE_W-1:0] active_d [N_CH];
  logic               pending_q, pending_d;
  logic [CW-1:0]      lost_cnt_q, lost_cnt_d;
  logic               lost_q, lost_d;
  logic               tick_q, tick_d;
  logic               sync_out_q, sync_out_d;
  logic               in_run, stay_run, run_next;
  logic               resync, step_adv, wrap, copy_now;

  // sync_q[1] is the synchronised level, sync_q[2] its previous value.
  always_ff @(posedge sys_clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[1:0], sync_in};
  end

  assign sync_edge = sync_q[1] & ~sync_q[2];

  always_ff @(posedge sys_clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (enable) state_d = slave ? ST_WAIT_SYNC : ST_RUN;
      ST_WAIT_SYNC: if (sync_edge) state_d = ST_RUN;
      ST_RUN:       state_d = ST_RUN;
      default:      state_d = ST_IDLE;
    endcase
    if (!enable) state_d = ST_IDLE;
  end

  always_comb begin
    in_run   = (state_q == ST_RUN);
    run_next = (state_d == ST_RUN);
    stay_run = in_run && run_next;
  end

  // Counters only advance while running in consecutive cycles, so entry into
  // RUN always starts from step 0 and exit leaves them cleared.
  always_comb begin
    resync   = in_run && slave && sync_edge;
    step_adv = (presc_q == PW'(CLK_DIV - 1));
    wrap     = in_run && step_adv && (step_q == '1) && !resync;
    presc_d  = '0;
    step_d   = '0;
    if (stay_run && !resync) begin
      if (step_adv) begin
        step_d = step_q + PHASE_W'(1);
      end else begin
        presc_d = presc_q + PW'(1);
        step_d  = step_q;
      end
    end
  end

  // Copy source is shadow_d so a write landing on the copy cycle is included.
  always_comb begin
    copy_now  = in_run ? ((pending_q || commit) && (wrap || resync)) : pending_q;
    pending_d = pending_q;
    if (copy_now)    pending_d = 1'b0;
    else if (commit) pending_d = 1'b1;
    for (int unsigned i = 0; i < N_CH; i++) begin
      shadow_d[i] = shadow_q[i];
      if (wr_en && (32'(wr_addr) == i)) shadow_d[i] = wr_data;
      active_d[i] = copy_now ? shadow_d[i] : active_q[i];
    end
  end

  always_comb begin
    lost_cnt_d = '0;
    lost_d     = 1'b0;
    if (stay_run && slave && !sync_edge) begin
      lost_cnt_d = lost_q ? lost_cnt_q : lost_cnt_q + CW'(1);
      lost_d     = lost_q || (lost_cnt_d == CW'(LOST_LIMIT));
    end
    tick_d     = run_next && (wrap || resync);
    sync_out_d = run_next && !slave && (step_d == '0);
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      presc_q    <= '0;
      step_q     <= '0;
      pending_q  <= 1'b0;
      lost_cnt_q <= '0;
      lost_q     <= 1'b0;
      tick_q     <= 1'b0;
      sync_out_q <= 1'b0;
      for (int unsigned i = 0; i < N_CH; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      presc_q    <= presc_d;
      step_q     <= step_d;
      pending_q  <= pending_d;
      lost_cnt_q <= lost_cnt_d;
      lost_q     <= lost_d;
      tick_q     <= tick_d;
      sync_out_q <= sync_out_d;
      for (int unsigned i = 0; i < N_CH; i++) begin
        shadow_q[i] <= shadow_d[i];
        active_q[i] <= active_d[i];
      end
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    phase_channel #(
      .PHASE_W (PHASE_W),
      .DUTY    (DUTY)
    ) u_ch (
      .sys_clk (sys_clk),
      .rst     (rst),
      .en_i    (stay_run),
      .step_i  (step_q),
      .phase_i (active_q[g]),
      .drive_o (trans[g])
    );
  end

  assign sync_out       = sync_out_q;
  assign period_tick    = tick_q;
  assign commit_pending = pending_q;
  assign sync_lost      = lost_q;

endmodule
